// File: rtl/freq_bcd_ranger.sv
// Sequential double-dabble binary-to-BCD converter with Hz/kHz auto-ranging
// for an 8-digit seven-segment display; outputs change only on completion.
`timescale 1ns/1ps

module freq_bcd_ranger #(
    parameter int          BIN_W     = 32,
    parameter logic [3:0]  KHZ_POINT = 4'd1,
    parameter logic [3:0]  NO_POINT  = 4'hF
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic [31:0]      Disp_Data,
    output logic [3:0]       point_pos,
    output logic             range_khz,
    output logic             busy,
    output logic             done
);

    localparam int DIGITS = 10;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FINAL} state_t;

    state_t              state, state_next;
    logic [WORK_W-1:0]   work;
    logic [CNT_W-1:0]    cnt;
    logic                load, shifting, finish;
    logic [BCD_W-1:0]    bcd;
    logic                hz_range;

    // One double-dabble step: correct every BCD nibble, then shift left by one.
    function automatic logic [WORK_W-1:0] dabble(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] t;
        t = w;
        for (int i = 0; i < DIGITS; i++) begin
            if (t[BIN_W+4*i +: 4] >= 4'd5)
                t[BIN_W+4*i +: 4] = t[BIN_W+4*i +: 4] + 4'd3;
        end
        return {t[WORK_W-2:0], 1'b0};
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == CNT_W'(BIN_W - 1)) state_next = FINAL;
            FINAL:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load     = (state == IDLE) && start;
        shifting = (state == SHIFT);
        finish   = (state == FINAL);
        busy     = (state != IDLE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            work <= '0;
            cnt  <= '0;
        end else if (load) begin
            work <= {{BCD_W{1'b0}}, bin_in};
            cnt  <= '0;
        end else if (shifting) begin
            work <= dabble(work);
            cnt  <= cnt + CNT_W'(1);
        end
    end

    assign bcd      = work[WORK_W-1:BIN_W];
    assign hz_range = (bcd[BCD_W-1 -: 8] == 8'h00);

    // kHz range drops the two lowest digits: one decimal place, truncated.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Disp_Data <= '0;
            point_pos <= NO_POINT;
            range_khz <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                if (hz_range) begin
                    Disp_Data <= bcd[31:0];
                    point_pos <= NO_POINT;
                    range_khz <= 1'b0;
                end else begin
                    Disp_Data <= bcd[39:8];
                    point_pos <= KHZ_POINT;
                    range_khz <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_bcd_ranger.sv
// Scoreboard bench for freq_bcd_ranger: directed conversions push expected
// display words; a negedge monitor pops and compares on every done pulse.
`timescale 1ns/1ps

module tb_freq_bcd_ranger;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  point;
        logic        khz;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] bin_in = '0;
    logic [31:0] Disp_Data;
    logic [3:0]  point_pos;
    logic        range_khz;
    logic        busy;
    logic        done;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          done_count = 0;
    int          cycle = 0;
    logic [31:0] shown_data = '0;
    int          last_done_cycle = 0;

    freq_bcd_ranger dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .bin_in    (bin_in),
        .Disp_Data (Disp_Data),
        .point_pos (point_pos),
        .range_khz (range_khz),
        .busy      (busy),
        .done      (done)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (done === 1'b1) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("disp_data", Disp_Data, e.data);
                    check("point_pos", {28'd0, point_pos}, {28'd0, e.point});
                    check("range_khz", {31'd0, range_khz}, {31'd0, e.khz});
                end
            end
        end
    end

    // Issue one conversion; returns at #1 after the edge that raises done.
    // inject_at > 0 pulses a competing start (bin_in=777) that must be ignored.
    task automatic convert(input logic [31:0] val, input logic [31:0] ed,
                           input logic [3:0] ep, input logic ek, input int inject_at);
        int n, busy_n;
        exp_q.push_back('{data: ed, point: ep, khz: ek});
        start  = 1'b1;
        bin_in = val;
        @(posedge Clk);
        #1;
        start  = 1'b0;
        bin_in = $urandom;
        busy_n = busy ? 1 : 0;
        n = 0;
        while (n < 100) begin
            @(posedge Clk);
            #1;
            n++;
            if (start) start = 1'b0;
            if (done) break;
            if (busy) busy_n++;
            if (n == 10) check("hold_during_busy", Disp_Data, shown_data);
            if (inject_at > 0 && n == inject_at) begin
                start  = 1'b1;
                bin_in = 32'd777;
            end
        end
        if (!done) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", n, 32'd33);
            check("busy_cycles", busy_n, 32'd33);
            check("busy_low_at_done", {31'd0, busy}, 32'd0);
            last_done_cycle = cycle;
        end
        shown_data = ed;
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) @(posedge Clk);
        #1;
    endtask

    initial begin
        int first_done, done_before;
        #12;
        check("rst_disp", Disp_Data, 32'd0);
        check("rst_point", {28'd0, point_pos}, 32'hF);
        check("rst_busy", {31'd0, busy}, 32'd0);
        Reset_n = 1'b1;
        idle_cycles(2);
        check("idle_range", {31'd0, range_khz}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);

        convert(32'd12345678, 32'h12345678, 4'hF, 1'b0, 0);
        idle_cycles(3);
        convert(32'd0,         32'h00000000, 4'hF, 1'b0, 0);
        convert(32'd99999999,  32'h99999999, 4'hF, 1'b0, 0);
        convert(32'd100000000, 32'h01000000, 4'd1, 1'b1, 0);
        convert(32'hFFFFFFFF,  32'h42949672, 4'd1, 1'b1, 0);

        // Competing start mid-conversion, then a start in the done cycle.
        idle_cycles(2);
        done_before = done_count;
        convert(32'd555, 32'h00000555, 4'hF, 1'b0, 10);
        first_done = last_done_cycle;
        convert(32'd2024, 32'h00002024, 4'hF, 1'b0, 0);
        check("back_to_back_gap", last_done_cycle - first_done, 32'd34);
        idle_cycles(40);
        check("single_done_each", done_count - done_before, 32'd2);

        // Reset asserted mid-conversion aborts with no done pulse.
        start  = 1'b1;
        bin_in = 32'd87654321;
        @(posedge Clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge Clk);
        #1;
        done_before = done_count;
        Reset_n = 1'b0;
        #1;
        check("abort_disp", Disp_Data, 32'd0);
        check("abort_point", {28'd0, point_pos}, 32'hF);
        check("abort_range", {31'd0, range_khz}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        idle_cycles(3);
        Reset_n = 1'b1;
        shown_data = '0;
        idle_cycles(40);
        check("abort_no_done", done_count - done_before, 32'd0);
        convert(32'd42, 32'h00000042, 4'hF, 1'b0, 0);

        idle_cycles(5);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
